chirp_nco: RTL and testbench
============================

# chirp_nco

Transmit-side FMCW chirp generator: a phase-accumulator NCO with a linear frequency ramp that produces the complex I/Q reference samples driving the mixer's tx_i/tx_q inputs. It sequences a frame of N chirps separated by programmable idle gaps. One sample is emitted per sample_en strobe, the ADC sample-rate tick, so the tx samples stay sample-aligned with the rx samples entering the mixer.

## Interface
- OUTPUT_WIDTH, 16, I/Q sample width; equals mixer INPUT_WIDTH
- PHASE_WIDTH, 32, phase accumulator and frequency word width
- LUT_ADDR_WIDTH, 10, quarter-wave ROM address width
- LEN_WIDTH, 16, width of chirp_len and idle_len

- clk  in  1  clock; everything is on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that starts a frame; honoured only in IDLE
- abort  in  1  one-cycle pulse that terminates the frame immediately
- sample_en  in  1  sample-rate tick
- f_start  in  PHASE_WIDTH  initial phase increment per sample; latched on start
- f_slope  in  PHASE_WIDTH  increment added to the frequency each sample (unsigned, mod 2^PHASE_WIDTH); latched on start
- chirp_len  in  LEN_WIDTH  samples per chirp; latched on start
- idle_len  in  LEN_WIDTH  sample_en ticks between chirps; latched on start
- num_chirps  in  8  chirps per frame; latched on start
- tx_i  out  OUTPUT_WIDTH  cosine sample, two's complement
- tx_q  out  OUTPUT_WIDTH  sine sample, two's complement
- valid_out  out  1  tx_i/tx_q hold a new sample this cycle
- chirp_start  out  1  coincides with valid_out of sample 0 of each chirp
- frame_done  out  1  coincides with valid_out of the last sample of the frame
- busy  out  1  frame in progress or samples still in the pipeline

## Operation
- FSM states: IDLE, RAMP, GAP.
- IDLE -> RAMP on start when chirp_len != 0 and num_chirps != 0. On this transition:
  - latch the configuration;
  - set phase = 0, freq = f_start, sample_cnt = 0, chirp_cnt = 0.
- A start with chirp_len == 0 or num_chirps == 0 is ignored: the FSM stays in IDLE.
- RAMP, on each sample_en:
  - issue the current phase to the pipeline;
  - update phase += freq, freq += f_slope, sample_cnt++.
- RAMP exit, on the sample_en where sample_cnt == chirp_len-1:
  - if chirp_cnt == num_chirps-1, go to IDLE;
  - else if idle_len == 0, stay in RAMP and begin the next chirp;
  - else go to GAP.
- GAP counts idle_len sample_en ticks and emits nothing. It then returns to RAMP.
- Every new chirp resets phase = 0 and freq = f_start, and increments chirp_cnt.
- Sample k of a chirp has phase k·f_start + f_slope·k(k-1)/2 (mod 2^PHASE_WIDTH).
- Phase-to-amplitude mapping:
  - quadrant = phase[MSB:MSB-1]; a = next LUT_ADDR_WIDTH bits, truncated;
  - ROM has 2^LUT_ADDR_WIDTH+1 entries, entry a = round(A·sin(a·π/2^(LUT_ADDR_WIDTH+1))), with A = 2^(OUTPUT_WIDTH-1)-1;
  - sin and cos use indices a and 2^LUT_ADDR_WIDTH-a, with sign and swap chosen per quadrant;
  - phase 0 gives exactly (A, 0); a quarter cycle gives exactly (0, A).
- abort, in any state:
  - FSM goes to IDLE next cycle;
  - in-flight pipeline samples are discarded, so valid_out, chirp_start and frame_done stay 0 from the next cycle on;
  - frame_done does not fire.
- abort and start in the same cycle: abort wins and start is ignored.
- start while not IDLE: ignored.
- sample_en in IDLE: ignored.
- Latched configuration is immune to input changes mid-frame.

## Timing
- Reset values: all outputs 0, FSM in IDLE, accumulators and counters 0.
- Latency: a sample_en accepted in RAMP at cycle n gives valid_out at cycle n+2. Stage 1 is the ROM address and quadrant; stage 2 is the ROM read, sign and swap.
- valid_out is a single-cycle pulse per sample. tx_i/tx_q hold their value between pulses.
- The first sample of a frame may use a sample_en in the cycle after start, at the earliest.
- busy rises the cycle after an accepted start. It falls the cycle after frame_done, or the cycle after abort.
- Reset mid-frame: immediate return to the reset values.

## Structure
- Package chirp_pkg: FSM state enum, quadrant decode constants, the default parameter values, and the amplitude constant A.
- Sub-module quarter_sine_rom: 2^LUT_ADDR_WIDTH+1 entries, two read ports (sin index, cos index), one-cycle registered read.

## Test plan
- Reset: assert rst mid-frame -> all outputs 0, busy 0, and the next start behaves as a fresh frame.
- f_start=2^30, f_slope=0, chirp_len=4, num_chirps=1, sample_en every cycle:
  - (tx_i, tx_q) = (A,0), (0,A), (-A,0), (0,-A) on 4 consecutive cycles, starting 2 cycles after the first sample_en;
  - chirp_start on the first sample, frame_done on the fourth.
- f_start=0, f_slope=2^24, chirp_len=5 -> internal phases 0, 0, 2^24, 3·2^24, 6·2^24; first two samples are (A,0).
- num_chirps=3, idle_len=2, chirp_len=3:
  - 3 chirp_start pulses, each chirp beginning with (A,0);
  - exactly 2 sample_en ticks without valid_out between chirps;
  - one frame_done.
- sample_en every 3rd cycle, abort during chirp 2:
  - valid_out spacing is 3 cycles;
  - no valid_out after abort+1, no frame_done, busy drops;
  - a following start runs correctly.
- start while busy, start with chirp_len=0, and start coincident with abort -> all ignored; output stream unchanged.

Source files
------------

// File: rtl/chirp_nco_pkg.sv
// Shared definitions for the FMCW chirp NCO: FSM states, quadrant codes,
// default widths and the elaboration-time quarter-sine table generator.
package chirp_pkg;
    localparam int DEF_OUTPUT_WIDTH   = 16;
    localparam int DEF_PHASE_WIDTH    = 32;
    localparam int DEF_LUT_ADDR_WIDTH = 10;
    localparam int DEF_LEN_WIDTH      = 16;
    localparam int AMP                = (1 << (DEF_OUTPUT_WIDTH - 1)) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    function automatic int amp_of(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    // Taylor series keeps table generation free of tool-specific math calls.
    function automatic int sine_entry(input int idx, input int addr_w, input int out_w);
        real x;
        real term;
        real acc;
        x    = 3.14159265358979323846 * real'(idx) / real'(1 << (addr_w + 1));
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return int'(acc * real'(amp_of(out_w)));
    endfunction
endpackage

// File: rtl/chirp_nco_quarter_sine_rom.sv
// Quarter-wave sine table, 2^LUT_ADDR_WIDTH+1 entries so that both 0 and
// full scale are exact; two registered read ports (sin and cos index).
module quarter_sine_rom
    import chirp_pkg::*;
#(
    parameter int LUT_ADDR_WIDTH = DEF_LUT_ADDR_WIDTH,
    parameter int OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    input  logic [LUT_ADDR_WIDTH:0]   i_sin_addr,
    input  logic [LUT_ADDR_WIDTH:0]   i_cos_addr,
    output logic [OUTPUT_WIDTH-1:0]   o_sin,
    output logic [OUTPUT_WIDTH-1:0]   o_cos
);
    localparam int DEPTH = (1 << LUT_ADDR_WIDTH) + 1;

    logic [OUTPUT_WIDTH-1:0] w_rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam logic [OUTPUT_WIDTH-1:0] ENTRY =
            OUTPUT_WIDTH'(sine_entry(g, LUT_ADDR_WIDTH, OUTPUT_WIDTH));
        assign w_rom[g] = ENTRY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sin <= '0;
            o_cos <= '0;
        end else if (i_en) begin
            o_sin <= w_rom[i_sin_addr];
            o_cos <= w_rom[i_cos_addr];
        end
    end
endmodule

// File: rtl/chirp_nco.sv
// FMCW chirp generator: linear-FM phase accumulator sequencing a frame of
// chirps and idle gaps, with a two-stage quarter-wave I/Q lookup.
module chirp_nco
    import chirp_pkg::*;
#(
    parameter int OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH,
    parameter int PHASE_WIDTH    = DEF_PHASE_WIDTH,
    parameter int LUT_ADDR_WIDTH = DEF_LUT_ADDR_WIDTH,
    parameter int LEN_WIDTH      = DEF_LEN_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic                    i_sample_en,
    input  logic [PHASE_WIDTH-1:0]  i_f_start,
    input  logic [PHASE_WIDTH-1:0]  i_f_slope,
    input  logic [LEN_WIDTH-1:0]    i_chirp_len,
    input  logic [LEN_WIDTH-1:0]    i_idle_len,
    input  logic [7:0]              i_num_chirps,
    output logic [OUTPUT_WIDTH-1:0] o_tx_i,
    output logic [OUTPUT_WIDTH-1:0] o_tx_q,
    output logic                    o_valid_out,
    output logic                    o_chirp_start,
    output logic                    o_frame_done,
    output logic                    o_busy
);
    localparam logic [LEN_WIDTH-1:0]    ONE_LEN = LEN_WIDTH'(1);
    localparam logic [LUT_ADDR_WIDTH:0] QTR     = (LUT_ADDR_WIDTH + 1)'(1 << LUT_ADDR_WIDTH);

    state_e                    r_state;
    logic [PHASE_WIDTH-1:0]    r_phase;
    logic [PHASE_WIDTH-1:0]    r_freq;
    logic [LEN_WIDTH-1:0]      r_sample_cnt;
    logic [LEN_WIDTH-1:0]      r_gap_cnt;
    logic [7:0]                r_chirp_cnt;
    logic [PHASE_WIDTH-1:0]    r_f_start;
    logic [PHASE_WIDTH-1:0]    r_f_slope;
    logic [LEN_WIDTH-1:0]      r_chirp_len;
    logic [LEN_WIDTH-1:0]      r_idle_len;
    logic [7:0]                r_num_chirps;

    logic [2:1]                r_vld_pipe;
    logic [2:1]                r_first_pipe;
    logic [2:1]                r_last_pipe;
    logic [1:0]                r_quad1;
    logic [1:0]                r_quad2;
    logic [LUT_ADDR_WIDTH-1:0] r_addr1;

    logic                      w_cfg_ok;
    logic                      w_issue;
    logic                      w_chirp_end;
    logic                      w_last_chirp;
    logic                      w_first;
    logic                      w_last;
    logic                      w_rom_en;
    logic [LUT_ADDR_WIDTH:0]   w_sin_addr;
    logic [LUT_ADDR_WIDTH:0]   w_cos_addr;
    logic [OUTPUT_WIDTH-1:0]   w_rom_sin;
    logic [OUTPUT_WIDTH-1:0]   w_rom_cos;

    assign w_cfg_ok     = (i_chirp_len != '0) && (i_num_chirps != '0);
    assign w_issue      = (r_state == ST_RAMP) && i_sample_en && !i_abort;
    assign w_chirp_end  = (r_sample_cnt == r_chirp_len - ONE_LEN);
    assign w_last_chirp = (r_chirp_cnt == r_num_chirps - 8'd1);
    assign w_first      = (r_sample_cnt == '0);
    assign w_last       = w_chirp_end && w_last_chirp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_phase      <= '0;
            r_freq       <= '0;
            r_sample_cnt <= '0;
            r_gap_cnt    <= '0;
            r_chirp_cnt  <= '0;
            r_f_start    <= '0;
            r_f_slope    <= '0;
            r_chirp_len  <= '0;
            r_idle_len   <= '0;
            r_num_chirps <= '0;
        end else if (i_abort) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start && w_cfg_ok) begin
                    r_f_start    <= i_f_start;
                    r_f_slope    <= i_f_slope;
                    r_chirp_len  <= i_chirp_len;
                    r_idle_len   <= i_idle_len;
                    r_num_chirps <= i_num_chirps;
                    r_phase      <= '0;
                    r_freq       <= i_f_start;
                    r_sample_cnt <= '0;
                    r_chirp_cnt  <= '0;
                    r_state      <= ST_RAMP;
                end
                ST_RAMP: if (i_sample_en) begin
                    if (w_chirp_end) begin
                        // every chirp restarts from phase 0 at f_start
                        r_sample_cnt <= '0;
                        r_phase      <= '0;
                        r_freq       <= r_f_start;
                        r_gap_cnt    <= '0;
                        if (w_last_chirp) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_chirp_cnt <= r_chirp_cnt + 8'd1;
                            r_state     <= (r_idle_len == '0) ? ST_RAMP : ST_GAP;
                        end
                    end else begin
                        r_phase      <= r_phase + r_freq;
                        r_freq       <= r_freq + r_f_slope;
                        r_sample_cnt <= r_sample_cnt + ONE_LEN;
                    end
                end
                ST_GAP: if (i_sample_en) begin
                    if (r_gap_cnt == r_idle_len - ONE_LEN) r_state <= ST_RAMP;
                    else                                   r_gap_cnt <= r_gap_cnt + ONE_LEN;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe   <= '0;
            r_first_pipe <= '0;
            r_last_pipe  <= '0;
            r_quad1      <= '0;
            r_quad2      <= '0;
            r_addr1      <= '0;
        end else begin
            r_vld_pipe   <= i_abort ? 2'b00 : {r_vld_pipe[1], w_issue};
            r_first_pipe <= {r_first_pipe[1], w_first};
            r_last_pipe  <= {r_last_pipe[1], w_last};
            if (w_issue) begin
                r_quad1 <= r_phase[PHASE_WIDTH-1 -: 2];
                r_addr1 <= r_phase[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
            end
            if (w_rom_en) r_quad2 <= r_quad1;
        end
    end

    assign w_rom_en   = r_vld_pipe[1] && !i_abort;
    assign w_sin_addr = {1'b0, r_addr1};
    assign w_cos_addr = QTR - {1'b0, r_addr1};

    quarter_sine_rom #(
        .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH),
        .OUTPUT_WIDTH   (OUTPUT_WIDTH)
    ) u_rom (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_rom_en),
        .i_sin_addr (w_sin_addr),
        .i_cos_addr (w_cos_addr),
        .o_sin      (w_rom_sin),
        .o_cos      (w_rom_cos)
    );

    // ROM holds |sin| and |cos| of the in-quadrant angle; rotate by quadrant.
    always_comb begin
        o_tx_i = w_rom_cos;
        o_tx_q = w_rom_sin;
        case (r_quad2)
            QUAD_0: begin o_tx_i = w_rom_cos;  o_tx_q = w_rom_sin;  end
            QUAD_1: begin o_tx_i = -w_rom_sin; o_tx_q = w_rom_cos;  end
            QUAD_2: begin o_tx_i = -w_rom_cos; o_tx_q = -w_rom_sin; end
            QUAD_3: begin o_tx_i = w_rom_sin;  o_tx_q = -w_rom_cos; end
            default: ;
        endcase
    end

    assign o_valid_out   = r_vld_pipe[2];
    assign o_chirp_start = r_vld_pipe[2] && r_first_pipe[2];
    assign o_frame_done  = r_vld_pipe[2] && r_last_pipe[2];
    assign o_busy        = (r_state != ST_IDLE) || (r_vld_pipe != 2'b00);
endmodule

// File: tb/tb_chirp_nco.sv
// Scoreboard bench for chirp_nco: stimulus pushes expected samples with
// their due cycle, a negedge monitor pops and compares on every valid_out.
module tb_chirp_nco;
    localparam int OW = 16;
    localparam int PW = 32;
    localparam int NW = 16;
    localparam int A  = 32767;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          sample_en = 1'b0;
    logic [PW-1:0] f_start = '0;
    logic [PW-1:0] f_slope = '0;
    logic [NW-1:0] chirp_len = '0;
    logic [NW-1:0] idle_len = '0;
    logic [7:0]    num_chirps = '0;
    logic [OW-1:0] tx_i;
    logic [OW-1:0] tx_q;
    logic          valid_out;
    logic          chirp_start;
    logic          frame_done;
    logic          busy;

    chirp_nco u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_sample_en   (sample_en),
        .i_f_start     (f_start),
        .i_f_slope     (f_slope),
        .i_chirp_len   (chirp_len),
        .i_idle_len    (idle_len),
        .i_num_chirps  (num_chirps),
        .o_tx_i        (tx_i),
        .o_tx_q        (tx_q),
        .o_valid_out   (valid_out),
        .o_chirp_start (chirp_start),
        .o_frame_done  (frame_done),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int i;
        int q;
        bit cs;
        bit fd;
        int at;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   QI [4] = '{A, 0, -A, 0};
    int   QQ [4] = '{0, A, 0, -A};

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input int i, input int q, input bit cs, input bit fd, input int at);
        exp_t e;
        e.i = i; e.q = q; e.cs = cs; e.fd = fd; e.at = at;
        sb.push_back(e);
    endfunction

    // Reference from the full angle of the truncated phase.
    function automatic void push_phase(input logic [31:0] ph, input bit cs, input bit fd, input int at);
        real th;
        th = 2.0 * 3.14159265358979 * real'(ph[31:20]) / 4096.0;
        push(int'(A * $cos(th)), int'(A * $sin(th)), cs, fd, at);
    endfunction

    always @(negedge clk) begin
        if (valid_out) begin
            if (sb.size() == 0) begin
                check("valid_out with empty scoreboard", int'(valid_out), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("tx_i", int'($signed(tx_i)), e.i);
                check("tx_q", int'($signed(tx_q)), e.q);
                check("chirp_start", int'(chirp_start), int'(e.cs));
                check("frame_done", int'(frame_done), int'(e.fd));
                if (e.at >= 0) check("sample cycle", cyc, e.at);
            end
        end else if (chirp_start || frame_done) begin
            check("strobe without valid_out", int'(chirp_start || frame_done), 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [31:0] fs, input logic [31:0] sl, input logic [15:0] cl,
                      input logic [15:0] il, input logic [7:0] nc);
        f_start = fs; f_slope = sl; chirp_len = cl; idle_len = il; num_chirps = nc;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            step(1);
            n++;
        end
        check({tag, " scoreboard drained"}, sb.size(), 0);
        sample_en = 1'b0;
    endtask

    // Quarter-cycle steps, with config inputs scrambled right after start.
    task automatic run_quad(input string tag);
        int s;
        s = cyc;
        check({tag, " busy before start"}, int'(busy), 0);
        go(32'h4000_0000, 32'h0, 16'd4, 16'd0, 8'd1);
        f_start = 32'h0123_4567; f_slope = 32'h1; chirp_len = 16'd9; num_chirps = 8'd5;
        sample_en = 1'b1;
        check({tag, " busy after start"}, int'(busy), 1);
        for (int k = 0; k < 4; k++) push(QI[k], QQ[k], k == 0, k == 3, s + 3 + k);
        step(5);
        check({tag, " busy at frame_done"}, int'(busy), 1);
        step(1);
        check({tag, " busy after frame_done"}, int'(busy), 0);
        sample_en = 1'b0;
        wait_drain(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int s;
        logic [31:0] ph [5];
        ph = '{32'd0, 32'd0, 32'd1 << 24, 32'd3 << 24, 32'd6 << 24};

        step(3);
        check("reset tx_i", int'(tx_i), 0);
        check("reset tx_q", int'(tx_q), 0);
        check("reset valid_out", int'(valid_out), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;
        step(2);

        run_quad("quad");

        // linear ramp from zero frequency
        s = cyc;
        go(32'h0, 32'h0100_0000, 16'd5, 16'd0, 8'd1);
        sample_en = 1'b1;
        for (int k = 0; k < 5; k++) push_phase(ph[k], k == 0, k == 4, s + 3 + k);
        wait_drain("slope");

        // three chirps with 2-tick gaps; a start mid-frame must be ignored
        s = cyc;
        go(32'h4000_0000, 32'h0, 16'd3, 16'd2, 8'd3);
        sample_en = 1'b1;
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 3; k++)
                push(QI[k], QQ[k], k == 0, (c == 2) && (k == 2), s + 3 + 5 * c + k);
        step(5);
        go(32'h0, 32'h0, 16'd1, 16'd0, 8'd1);
        wait_drain("multi");

        // starts that must be ignored
        sample_en = 1'b1;
        go(32'h4000_0000, 32'h0, 16'd0, 16'd0, 8'd1);
        check("start chirp_len=0 busy", int'(busy), 0);
        go(32'h4000_0000, 32'h0, 16'd4, 16'd0, 8'd0);
        check("start num_chirps=0 busy", int'(busy), 0);
        abort = 1'b1;
        go(32'h4000_0000, 32'h0, 16'd4, 16'd0, 8'd1);
        abort = 1'b0;
        check("start with abort busy", int'(busy), 0);
        step(6);
        sample_en = 1'b0;
        check("ignored starts no samples", sb.size(), 0);

        // sample_en every 3rd cycle, abort during chirp 2
        s = cyc;
        go(32'h4000_0000, 32'h0, 16'd4, 16'd1, 8'd3);
        for (int k = 0; k < 4; k++) push(QI[k], QQ[k], k == 0, 1'b0, s + 3 + 3 * k);
        push(A, 0, 1'b1, 1'b0, s + 18);
        for (int j = 1; j <= 26; j++) begin
            sample_en = ((j - 1) % 3) == 0;
            abort     = (j == 20);
            if (j == 19) check("abort busy before", int'(busy), 1);
            if (j == 21) check("abort busy after", int'(busy), 0);
            step(1);
        end
        abort = 1'b0;
        sample_en = 1'b0;
        check("abort scoreboard drained", sb.size(), 0);
        run_quad("post-abort");

        // reset in the middle of a frame
        s = cyc;
        go(32'h4000_0000, 32'h0, 16'd8, 16'd0, 8'd1);
        sample_en = 1'b1;
        push(QI[0], QQ[0], 1'b1, 1'b0, s + 3);
        push(QI[1], QQ[1], 1'b0, 1'b0, s + 4);
        step(4);
        rst = 1'b1;
        #1;
        check("midreset tx_i", int'(tx_i), 0);
        check("midreset tx_q", int'(tx_q), 0);
        check("midreset valid_out", int'(valid_out), 0);
        check("midreset busy", int'(busy), 0);
        step(2);
        rst = 1'b0;
        sample_en = 1'b0;
        step(1);
        check("midreset scoreboard drained", sb.size(), 0);
        run_quad("post-reset");

        step(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
